// File: rtl/frame_link_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// frame_link_pkg : link flag bytes, confirm codes, FSM encoding. Rev 1.0
// ------------------------------------------------------------------
package frame_link_pkg;

  localparam logic [7:0] FRAME_START = 8'h06;
  localparam logic [7:0] FRAME_END   = 8'h07;
  localparam logic [7:0] ESC_VAL     = 8'h14;
  localparam logic [7:0] ESC_XOR     = 8'h20;
  localparam logic [7:0] OKAY        = 8'h05;
  localparam logic [7:0] ERROR       = 8'h04;

  typedef enum logic [5:0] {
    ST_IDLE        = 6'b000001,
    ST_TX_FRAME    = 6'b000010,
    ST_TX_WAIT_ACK = 6'b000100,
    ST_RX_FRAME    = 6'b001000,
    ST_RX_HOLD     = 6'b010000,
    ST_TX_CONF     = 6'b100000
  } state_e;

  function automatic logic needs_esc(input logic [7:0] b);
    return (b == FRAME_START) || (b == FRAME_END) || (b == ESC_VAL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_link_ctrl_stuffer.sv
`default_nettype none
// ------------------------------------------------------------------
// frame_stuffer : emits START, byte-stuffed frame, END; one byte per tx_ready. Rev 1.0
// ------------------------------------------------------------------
module frame_stuffer
  import frame_link_pkg::*;
#(
  parameter int FRAME_BYTES = 75,
  parameter int CNT_W       = $clog2(FRAME_BYTES + 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [8*FRAME_BYTES-1:0] frame_i,
  input  logic                     start_i,
  input  logic                     tx_ready_i,
  output logic [7:0]               tx_byte_o,
  output logic                     tx_valid_o,
  output logic                     done_o
);

  // pos 0 is the START flag, 1..FRAME_BYTES the payload, FRAME_BYTES+1 the END flag
  localparam logic [CNT_W-1:0] END_POS = CNT_W'(FRAME_BYTES + 1);

  logic                     active_q;
  logic                     esc_q;
  logic                     tx_valid_q;
  logic                     done_q;
  logic [CNT_W-1:0]         pos_q;
  logic [7:0]               tx_byte_q;
  logic [8*FRAME_BYTES-1:0] shift_q;
  logic [7:0]               w_cur;

  assign w_cur      = shift_q[8*FRAME_BYTES-1 -: 8];
  assign tx_byte_o  = tx_byte_q;
  assign tx_valid_o = tx_valid_q;
  assign done_o     = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q   <= 1'b0;
      esc_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      pos_q      <= '0;
      tx_byte_q  <= '0;
      shift_q    <= '0;
    end else begin
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      if (start_i) begin
        active_q <= 1'b1;
        esc_q    <= 1'b0;
        pos_q    <= '0;
        shift_q  <= frame_i;
      end else if (active_q && tx_ready_i) begin
        tx_valid_q <= 1'b1;
        if (pos_q == '0) begin
          tx_byte_q <= FRAME_START;
          pos_q     <= pos_q + CNT_W'(1);
        end else if (pos_q == END_POS) begin
          tx_byte_q <= FRAME_END;
          active_q  <= 1'b0;
          done_q    <= 1'b1;
        end else if (esc_q) begin
          tx_byte_q <= w_cur ^ ESC_XOR;
          esc_q     <= 1'b0;
          pos_q     <= pos_q + CNT_W'(1);
          shift_q   <= shift_q << 8;
        end else if (needs_esc(w_cur)) begin
          // payload byte stays at the head of the shifter until its escaped half goes out
          tx_byte_q <= ESC_VAL;
          esc_q     <= 1'b1;
        end else begin
          tx_byte_q <= w_cur;
          pos_q     <= pos_q + CNT_W'(1);
          shift_q   <= shift_q << 8;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_link_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// frame_link_ctrl : byte-stuffed frame link with ACK/retry TX and length-checked RX. Rev 1.0
// ------------------------------------------------------------------
module frame_link_ctrl
  import frame_link_pkg::*;
#(
  parameter int FRAME_BYTES = 75,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = $clog2(FRAME_BYTES + 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_byte_i,
  input  logic                     rx_valid_i,
  output logic [7:0]               tx_byte_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i,
  input  logic [8*FRAME_BYTES-1:0] fin_i,
  input  logic                     fin_valid_i,
  output logic                     fin_ready_o,
  output logic [8*FRAME_BYTES-1:0] fout_o,
  output logic                     fout_valid_o,
  input  logic                     confirm_i,
  input  logic [7:0]               conf_code_i,
  input  logic                     semafor_in_i,
  output logic                     semafor_out_o,
  output logic [7:0]               ack_code_o,
  output logic                     ack_valid_o,
  output logic                     link_err_o
);

  localparam int               FW       = 8 * FRAME_BYTES;
  localparam int               TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int               RTY_W    = $clog2(MAX_RETRY + 2);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BYTES);

  state_e           state_q;
  logic             fin_ready_q;
  logic [FW-1:0]    frame_q;
  logic [TMR_W-1:0] timer_q;
  logic [RTY_W-1:0] retry_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic             rx_esc_q;
  logic [FW-1:0]    fout_q;
  logic             fout_valid_q;
  logic             semafor_q;
  logic [7:0]       ack_code_q;
  logic             ack_valid_q;
  logic             link_err_q;
  logic [7:0]       conf_byte_q;
  logic             conf_valid_q;

  logic             w_fin_acc;
  logic             w_ack_fail;
  logic             w_retx;
  logic             w_stuff_start;
  logic [FW-1:0]    w_stuff_frame;
  logic [7:0]       w_stuff_byte;
  logic             w_stuff_valid;
  logic             w_stuff_done;
  logic [7:0]       w_rx_data;

  assign w_fin_acc  = (state_q == ST_IDLE) && fin_valid_i && fin_ready_q;
  assign w_ack_fail = (state_q == ST_TX_WAIT_ACK) &&
                      ((rx_valid_i && (rx_byte_i != OKAY)) || (timer_q == TMR_LAST));
  assign w_retx     = w_ack_fail && (retry_q < RTY_MAX);

  // the first send is fed straight from fin so the stuffer starts on the accept edge
  assign w_stuff_start = w_fin_acc || w_retx;
  assign w_stuff_frame = w_fin_acc ? fin_i : frame_q;
  assign w_rx_data     = rx_esc_q ? (rx_byte_i ^ ESC_XOR) : rx_byte_i;

  frame_stuffer #(
    .FRAME_BYTES (FRAME_BYTES),
    .CNT_W       (CNT_W)
  ) u_stuffer (
    .clk        (clk),
    .rst        (rst),
    .frame_i    (w_stuff_frame),
    .start_i    (w_stuff_start),
    .tx_ready_i (tx_ready_i),
    .tx_byte_o  (w_stuff_byte),
    .tx_valid_o (w_stuff_valid),
    .done_o     (w_stuff_done)
  );

  assign tx_byte_o     = conf_valid_q ? conf_byte_q : w_stuff_byte;
  assign tx_valid_o    = conf_valid_q | w_stuff_valid;
  assign fin_ready_o   = fin_ready_q;
  assign fout_o        = fout_q;
  assign fout_valid_o  = fout_valid_q;
  assign semafor_out_o = semafor_q;
  assign ack_code_o    = ack_code_q;
  assign ack_valid_o   = ack_valid_q;
  assign link_err_o    = link_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fin_ready_q  <= 1'b0;
      frame_q      <= '0;
      timer_q      <= '0;
      retry_q      <= '0;
      rx_cnt_q     <= '0;
      rx_esc_q     <= 1'b0;
      fout_q       <= '0;
      fout_valid_q <= 1'b0;
      semafor_q    <= 1'b0;
      ack_code_q   <= '0;
      ack_valid_q  <= 1'b0;
      link_err_q   <= 1'b0;
      conf_byte_q  <= '0;
      conf_valid_q <= 1'b0;
    end else begin
      ack_valid_q  <= 1'b0;
      link_err_q   <= 1'b0;
      conf_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          fin_ready_q <= 1'b1;
          if (w_fin_acc) begin
            frame_q     <= fin_i;
            retry_q     <= '0;
            fin_ready_q <= 1'b0;
            state_q     <= ST_TX_FRAME;
          end else if (rx_valid_i && (rx_byte_i == FRAME_START) && !semafor_in_i) begin
            rx_cnt_q    <= '0;
            rx_esc_q    <= 1'b0;
            semafor_q   <= 1'b1;
            fin_ready_q <= 1'b0;
            state_q     <= ST_RX_FRAME;
          end
        end

        ST_TX_FRAME: begin
          if (w_stuff_done) begin
            timer_q <= '0;
            state_q <= ST_TX_WAIT_ACK;
          end
        end

        ST_TX_WAIT_ACK: begin
          timer_q <= timer_q + TMR_W'(1);
          if (rx_valid_i) begin
            ack_code_q  <= rx_byte_i;
            ack_valid_q <= 1'b1;
          end
          if (rx_valid_i && (rx_byte_i == OKAY)) begin
            fin_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (w_retx) begin
            retry_q <= retry_q + RTY_W'(1);
            state_q <= ST_TX_FRAME;
          end else if (w_ack_fail) begin
            link_err_q  <= 1'b1;
            fin_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        ST_RX_FRAME: begin
          if (rx_valid_i) begin
            if (rx_esc_q || !needs_esc(rx_byte_i)) begin
              rx_esc_q <= 1'b0;
              if (rx_cnt_q == CNT_FULL) begin
                link_err_q  <= 1'b1;
                conf_byte_q <= ERROR;
                state_q     <= ST_TX_CONF;
              end else begin
                for (int k = 0; k < FRAME_BYTES; k++) begin
                  if (rx_cnt_q == CNT_W'(k)) fout_q[FW-1-8*k -: 8] <= w_rx_data;
                end
                rx_cnt_q <= rx_cnt_q + CNT_W'(1);
              end
            end else if (rx_byte_i == ESC_VAL) begin
              rx_esc_q <= 1'b1;
            end else if (rx_byte_i == FRAME_START) begin
              rx_cnt_q <= '0;
            end else if (rx_cnt_q == CNT_FULL) begin
              fout_valid_q <= 1'b1;
              state_q      <= ST_RX_HOLD;
            end else begin
              link_err_q  <= 1'b1;
              conf_byte_q <= ERROR;
              state_q     <= ST_TX_CONF;
            end
          end
        end

        ST_RX_HOLD: begin
          if (confirm_i) begin
            fout_valid_q <= 1'b0;
            conf_byte_q  <= conf_code_i;
            state_q      <= ST_TX_CONF;
          end
        end

        ST_TX_CONF: begin
          if (tx_ready_i) begin
            conf_valid_q <= 1'b1;
            semafor_q    <= 1'b0;
            fin_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end

        default: begin
          fin_ready_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_link_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_frame_link_ctrl : table-driven and scoreboarded bench for frame_link_ctrl. Rev 1.0
// ------------------------------------------------------------------
module tb_frame_link_ctrl;

  localparam int FB = 4;
  localparam int TO = 50;
  localparam int MR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic [7:0]    tx_byte;
  logic          tx_valid;
  logic          tx_ready;
  logic [31:0]   fin;
  logic          fin_valid;
  logic          fin_ready;
  logic [31:0]   fout;
  logic          fout_valid;
  logic          confirm;
  logic [7:0]    conf_code;
  logic          semafor_in;
  logic          semafor_out;
  logic [7:0]    ack_code;
  logic          ack_valid;
  logic          link_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp_q [$];
  int         start_t [$];
  int         end_t [$];
  int         err_t [$];
  logic [7:0] mon_e;

  typedef struct {
    logic [7:0]  rx [10];
    int          n;
    logic        ok;
    logic [31:0] fout;
    logic [7:0]  conf;
  } rx_vec_t;

  rx_vec_t     rv [5];
  logic [31:0] tx_fins [3];
  logic [7:0]  lit [8];

  frame_link_ctrl #(
    .FRAME_BYTES (FB),
    .TIMEOUT_CYC (TO),
    .MAX_RETRY   (MR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_byte_i     (rx_byte),
    .rx_valid_i    (rx_valid),
    .tx_byte_o     (tx_byte),
    .tx_valid_o    (tx_valid),
    .tx_ready_i    (tx_ready),
    .fin_i         (fin),
    .fin_valid_i   (fin_valid),
    .fin_ready_o   (fin_ready),
    .fout_o        (fout),
    .fout_valid_o  (fout_valid),
    .confirm_i     (confirm),
    .conf_code_i   (conf_code),
    .semafor_in_i  (semafor_in),
    .semafor_out_o (semafor_out),
    .ack_code_o    (ack_code),
    .ack_valid_o   (ack_valid),
    .link_err_o    (link_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // every transmitted byte is checked against the head of the expected queue
  always @(negedge clk) begin
    if (tx_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tx_unexpected: got %0h, expected no byte (cycle %0d)", tx_byte, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tx_byte", 32'(tx_byte), 32'(mon_e));
      end
      if (tx_byte == 8'h06) start_t.push_back(cyc);
      if (tx_byte == 8'h07) end_t.push_back(cyc);
    end
    if (link_err) err_t.push_back(cyc);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic push_stuffed(input logic [31:0] f);
    logic [7:0] b;
    exp_q.push_back(8'h06);
    for (int k = 0; k < FB; k++) begin
      b = f[31-8*k -: 8];
      if (b == 8'h06 || b == 8'h07 || b == 8'h14) begin
        exp_q.push_back(8'h14);
        exp_q.push_back(b ^ 8'h20);
      end else begin
        exp_q.push_back(b);
      end
    end
    exp_q.push_back(8'h07);
  endtask

  task automatic wait_drain(input int max);
    int k = 0;
    while (exp_q.size() != 0 && k < max) begin
      tick();
      k++;
    end
    chk("tx_drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_fin(input logic [31:0] f);
    fin       = f;
    fin_valid = 1'b1;
    tick();
    fin_valid = 1'b0;
  endtask

  task automatic tx_acked(input logic [31:0] f);
    push_stuffed(f);
    send_fin(f);
    wait_drain(100);
    tick();
    tick();
    send_rx(8'h05);
    chkb("ack_valid", ack_valid, 1'b1);
    chk("ack_code", 32'(ack_code), 32'h05);
  endtask

  task automatic chk_reset_outs();
    chkb("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    chkb("rst_fin_ready", fin_ready, 1'b0);
    chk("rst_fout", fout, 32'd0);
    chkb("rst_fout_valid", fout_valid, 1'b0);
    chkb("rst_semafor", semafor_out, 1'b0);
    chk("rst_ack_code", 32'(ack_code), 32'd0);
    chkb("rst_ack_valid", ack_valid, 1'b0);
    chkb("rst_link_err", link_err, 1'b0);
  endtask

  task automatic run_rx(input int i);
    if (!rv[i].ok) exp_q.push_back(8'h04);
    for (int j = 0; j < rv[i].n; j++) send_rx(rv[i].rx[j]);
    chkb($sformatf("rx%0d_fout_valid", i), fout_valid, rv[i].ok);
    chkb($sformatf("rx%0d_link_err", i), link_err, !rv[i].ok);
    chkb($sformatf("rx%0d_semafor_busy", i), semafor_out, 1'b1);
    if (rv[i].ok) begin
      chk($sformatf("rx%0d_fout", i), fout, rv[i].fout);
      exp_q.push_back(rv[i].conf);
      conf_code = rv[i].conf;
      confirm   = 1'b1;
      tick();
      confirm   = 1'b0;
      chkb($sformatf("rx%0d_fout_valid_clr", i), fout_valid, 1'b0);
    end
    wait_drain(20);
    chkb($sformatf("rx%0d_semafor_free", i), semafor_out, 1'b0);
    tick();
    chkb($sformatf("rx%0d_fin_ready", i), fin_ready, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int g;

    rv[0] = '{'{8'h06, 8'hAA, 8'h14, 8'h27, 8'hBB, 8'hCC, 8'h07, 8'h00, 8'h00, 8'h00},
              7, 1'b1, 32'hAA07BBCC, 8'h05};
    rv[1] = '{'{8'h06, 8'hAA, 8'hBB, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              4, 1'b0, 32'h0, 8'h00};
    rv[2] = '{'{8'h06, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h00, 8'h00, 8'h00, 8'h00},
              6, 1'b0, 32'h0, 8'h00};
    rv[3] = '{'{8'h06, 8'h11, 8'h06, 8'h22, 8'h33, 8'h44, 8'h55, 8'h07, 8'h00, 8'h00},
              8, 1'b1, 32'h22334455, 8'h5A};
    rv[4] = '{'{8'h06, 8'h14, 8'h26, 8'h14, 8'h27, 8'h14, 8'h34, 8'h01, 8'h07, 8'h00},
              9, 1'b1, 32'h06071401, 8'h3C};
    tx_fins = '{32'h11062214, 32'h00010203, 32'h07071414};
    lit     = '{8'h06, 8'h11, 8'h14, 8'h26, 8'h22, 8'h14, 8'h34, 8'h07};

    rst        = 1'b1;
    rx_byte    = 8'h00;
    rx_valid   = 1'b0;
    tx_ready   = 1'b1;
    fin        = 32'h0;
    fin_valid  = 1'b0;
    confirm    = 1'b0;
    conf_code  = 8'h00;
    semafor_in = 1'b0;
    repeat (3) tick();
    chk_reset_outs();
    rst = 1'b0;
    tick();
    tick();

    // TX frames with OKAY acknowledgement
    for (int i = 0; i < 3; i++) begin
      chkb("tx_fin_ready_idle", fin_ready, 1'b1);
      if (i == 0) begin
        foreach (lit[j]) exp_q.push_back(lit[j]);
      end else begin
        push_stuffed(tx_fins[i]);
      end
      send_fin(tx_fins[i]);
      if (i == 0) begin
        chkb("tx_lat_first", tx_valid, 1'b0);
        chkb("tx_fin_ready_busy", fin_ready, 1'b0);
        tick();
        chkb("tx_lat_second", tx_valid, 1'b1);
      end
      if (i == 1) begin
        tick();
        tx_ready = 1'b0;
        repeat (3) tick();
        tx_ready = 1'b1;
      end
      wait_drain(100);
      tick();
      tick();
      send_rx(8'h05);
      chkb("tx_ack_valid", ack_valid, 1'b1);
      chk("tx_ack_code", 32'(ack_code), 32'h05);
      chkb("tx_ack_link_err", link_err, 1'b0);
      chkb("tx_back_idle", fin_ready, 1'b1);
    end

    // RX frames: good, short, overlong, resync, escaped flags
    for (int i = 0; i < 5; i++) run_rx(i);

    // no reply: first send plus MR retransmits, then give up
    start_t.delete();
    end_t.delete();
    err_t.delete();
    repeat (MR + 1) push_stuffed(32'hDEAD0714);
    send_fin(32'hDEAD0714);
    k = 0;
    while (err_t.size() == 0 && k < 600) begin
      tick();
      k++;
    end
    chk("giveup_err_seen", 32'(err_t.size()), 32'd1);
    chk("giveup_sends", 32'(start_t.size()), 32'(MR + 1));
    chk("giveup_drain", 32'(exp_q.size()), 32'd0);
    chkb("giveup_idle", fin_ready, 1'b1);
    if (start_t.size() == MR + 1 && end_t.size() == MR + 1 && err_t.size() == 1) begin
      for (int i = 0; i < MR; i++) begin
        g = start_t[i+1] - end_t[i];
        chkb($sformatf("retx_gap%0d_%0d", i, g), (g >= TO && g <= TO + 3), 1'b1);
      end
      g = err_t[0] - end_t[MR];
      chkb($sformatf("giveup_gap_%0d", g), (g >= TO && g <= TO + 3), 1'b1);
    end
    repeat (3) tick();
    chk("giveup_single_err", 32'(err_t.size()), 32'd1);

    // NAK then OKAY: frame sent twice, no error
    start_t.delete();
    end_t.delete();
    err_t.delete();
    repeat (2) push_stuffed(32'h01020304);
    send_fin(32'h01020304);
    k = 0;
    while (end_t.size() < 1 && k < 100) begin
      tick();
      k++;
    end
    tick();
    tick();
    send_rx(8'h04);
    chkb("nak_ack_valid", ack_valid, 1'b1);
    chk("nak_ack_code", 32'(ack_code), 32'h04);
    k = 0;
    while (end_t.size() < 2 && k < 100) begin
      tick();
      k++;
    end
    tick();
    tick();
    send_rx(8'h05);
    chk("nak_ok_ack_code", 32'(ack_code), 32'h05);
    repeat (3) tick();
    chk("nak_sends", 32'(start_t.size()), 32'd2);
    chk("nak_no_err", 32'(err_t.size()), 32'd0);
    chkb("nak_idle", fin_ready, 1'b1);

    // fin and RX start in the same cycle: TX wins
    push_stuffed(32'hA1B2C3D4);
    fin       = 32'hA1B2C3D4;
    fin_valid = 1'b1;
    rx_byte   = 8'h06;
    rx_valid  = 1'b1;
    tick();
    fin_valid = 1'b0;
    rx_valid  = 1'b0;
    chkb("collide_semafor", semafor_out, 1'b0);
    wait_drain(100);
    tick();
    tick();
    chkb("collide_semafor_end", semafor_out, 1'b0);
    send_rx(8'h05);
    chk("collide_ack_code", 32'(ack_code), 32'h05);

    // peer owns the link: RX start is ignored
    semafor_in = 1'b1;
    send_rx(8'h06);
    chkb("peer_semafor", semafor_out, 1'b0);
    chkb("peer_idle", fin_ready, 1'b1);
    send_rx(8'hAA);
    send_rx(8'h07);
    tick();
    chkb("peer_no_fout", fout_valid, 1'b0);
    semafor_in = 1'b0;

    // reset part way through a TX frame
    push_stuffed(32'h11062214);
    send_fin(32'h11062214);
    k = 0;
    while (exp_q.size() > 5 && k < 50) begin
      tick();
      k++;
    end
    rst = 1'b1;
    tick();
    chk_reset_outs();
    rst = 1'b0;
    exp_q.delete();
    tick();
    tick();
    tx_acked(32'h55667788);

    // reset part way through an RX frame
    send_rx(8'h06);
    send_rx(8'hAA);
    send_rx(8'hBB);
    chkb("midrx_semafor", semafor_out, 1'b1);
    rst = 1'b1;
    tick();
    chk_reset_outs();
    rst = 1'b0;
    tick();
    tick();
    run_rx(0);

    repeat (5) tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
